multicycle_comparator: RTL and testbench

Sequential, parametrised magnitude comparator for wide operands: compares DataA and DataB one slice per clock, most significant slice first, and stops at the first differing slice. It replaces the single-cycle combinational comparator on datapaths too wide to compare in one cycle. Signed/unsigned mode is selected at run time. Completion is reported with a start/busy/done handshake.

---
 rtl/multicycle_comparator_if.sv | 39 +++
 rtl/multicycle_comparator.sv | 109 ++++++++++
 tb/tb_multicycle_comparator.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_comparator_if.sv
// Start/busy/done handshake, operands and result flags of the multicycle comparator.
// The requester holds the master modport and the comparator holds the slave modport.
interface multicycle_comparator_if #(
  parameter int unsigned NrOfBits = 64
);
  logic                Start;
  logic                TwosComplement;
  logic [NrOfBits-1:0] DataA;
  logic [NrOfBits-1:0] DataB;
  logic                Busy;
  logic                Done;
  logic                A_EQ_B;
  logic                A_GT_B;
  logic                A_LT_B;

  modport master (
    output Start,
    output TwosComplement,
    output DataA,
    output DataB,
    input  Busy,
    input  Done,
    input  A_EQ_B,
    input  A_GT_B,
    input  A_LT_B
  );

  modport slave (
    input  Start,
    input  TwosComplement,
    input  DataA,
    input  DataB,
    output Busy,
    output Done,
    output A_EQ_B,
    output A_GT_B,
    output A_LT_B
  );
endinterface

// File: rtl/multicycle_comparator.sv
// Sequential magnitude comparator: examines one SliceBits-wide slice per cycle, most
// significant slice first, and stops at the first slice that differs.
module multicycle_comparator #(
  parameter int unsigned NrOfBits  = 64,
  parameter int unsigned SliceBits = 16
) (
  input logic                    Clock,
  input logic                    Reset,
  multicycle_comparator_if.slave bus
);
  localparam int unsigned NrOfSlices = NrOfBits / SliceBits;
  localparam int unsigned CntW       = (NrOfSlices > 1) ? $clog2(NrOfSlices) : 1;
  localparam logic [CntW-1:0]      LastIdx = CntW'(NrOfSlices - 1);
  localparam logic [SliceBits-1:0] MsbMask = SliceBits'(1) << (SliceBits - 1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e              state_q, state_d;
  logic [NrOfBits-1:0] a_q, a_d;
  logic [NrOfBits-1:0] b_q, b_d;
  logic                tc_q, tc_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                done_q, done_d;
  logic                eq_q, eq_d;
  logic                gt_q, gt_d;
  logic                lt_q, lt_d;
  logic [SliceBits-1:0] flip, slice_a, slice_b;

  // Operands shift left after each equal slice, so the slice under test is always on top.
  // Flipping both sign bits turns the signed top-slice compare into an unsigned one.
  always_comb begin
    flip    = (tc_q && (cnt_q == LastIdx)) ? MsbMask : '0;
    slice_a = a_q[NrOfBits-1 -: SliceBits] ^ flip;
    slice_b = b_q[NrOfBits-1 -: SliceBits] ^ flip;
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    tc_d    = tc_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    eq_d    = eq_q;
    gt_d    = gt_q;
    lt_d    = lt_q;
    unique case (state_q)
      StIdle: begin
        if (bus.Start) begin
          a_d     = bus.DataA;
          b_d     = bus.DataB;
          tc_d    = bus.TwosComplement;
          cnt_d   = LastIdx;
          state_d = StRun;
        end
      end
      StRun: begin
        if (slice_a > slice_b) begin
          {eq_d, gt_d, lt_d} = 3'b010;
          done_d             = 1'b1;
          state_d            = StIdle;
        end else if (slice_a < slice_b) begin
          {eq_d, gt_d, lt_d} = 3'b001;
          done_d             = 1'b1;
          state_d            = StIdle;
        end else if (cnt_q == '0) begin
          {eq_d, gt_d, lt_d} = 3'b100;
          done_d             = 1'b1;
          state_d            = StIdle;
        end else begin
          cnt_d = cnt_q - CntW'(1);
          a_d   = a_q << SliceBits;
          b_d   = b_q << SliceBits;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= StIdle;
      done_q  <= 1'b0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      eq_q    <= eq_d;
      gt_q    <= gt_d;
      lt_q    <= lt_d;
    end
  end

  // Operand registers carry no reset; they are always loaded before use.
  always_ff @(posedge Clock) begin
    a_q   <= a_d;
    b_q   <= b_d;
    tc_q  <= tc_d;
    cnt_q <= cnt_d;
  end

  assign bus.Busy   = (state_q == StRun);
  assign bus.Done   = done_q;
  assign bus.A_EQ_B = eq_q;
  assign bus.A_GT_B = gt_q;
  assign bus.A_LT_B = lt_q;
endmodule

// File: tb/tb_multicycle_comparator.sv
// Self-checking bench: a 64-bit/16-bit-slice and an 8-bit/8-bit-slice comparator,
// with expected flags and latency queued at Start and checked at Done.
module tb_multicycle_comparator;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multicycle_comparator_if #(.NrOfBits(64)) m64 ();
  multicycle_comparator_if #(.NrOfBits(8))  m8 ();

  multicycle_comparator #(.NrOfBits(64), .SliceBits(16)) dut64 (
    .Clock(clk), .Reset(rst), .bus(m64.slave)
  );
  multicycle_comparator #(.NrOfBits(8), .SliceBits(8)) dut8 (
    .Clock(clk), .Reset(rst), .bus(m8.slave)
  );

  typedef struct {
    logic [2:0] flags;  // {eq, gt, lt}
    int         lat;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic exp_t model(bit sel8, logic [63:0] a, logic [63:0] b, bit tc);
    exp_t e;
    logic gt, lt;
    bit   found;
    if (sel8) begin
      gt    = tc ? ($signed(a[7:0]) > $signed(b[7:0])) : (a[7:0] > b[7:0]);
      lt    = tc ? ($signed(a[7:0]) < $signed(b[7:0])) : (a[7:0] < b[7:0]);
      e.lat = 1;
    end else begin
      gt    = tc ? ($signed(a) > $signed(b)) : (a > b);
      lt    = tc ? ($signed(a) < $signed(b)) : (a < b);
      e.lat = 4;
      found = 1'b0;
      for (int k = 3; k >= 0; k--) begin
        if (!found && (a[k*16 +: 16] != b[k*16 +: 16])) begin
          e.lat = 4 - k;
          found = 1'b1;
        end
      end
    end
    e.flags = {~gt & ~lt, gt, lt};
    return e;
  endfunction

  // Called at a negedge; returns at the negedge of the first cycle after the Start edge.
  task automatic drive_start(bit sel8, logic [63:0] a, logic [63:0] b, bit tc);
    if (sel8) begin
      m8.DataA = a[7:0]; m8.DataB = b[7:0]; m8.TwosComplement = tc; m8.Start = 1'b1;
    end else begin
      m64.DataA = a; m64.DataB = b; m64.TwosComplement = tc; m64.Start = 1'b1;
    end
    sb.push_back(model(sel8, a, b, tc));
    @(negedge clk);
    if (sel8) begin
      m8.Start = 1'b0; m8.DataA = 8'($urandom); m8.DataB = 8'($urandom);
      m8.TwosComplement = ~tc;
    end else begin
      m64.Start = 1'b0; m64.DataA = {$urandom, $urandom}; m64.DataB = {$urandom, $urandom};
      m64.TwosComplement = ~tc;
    end
  endtask

  // Counts cycles after the Start edge until Done (bounded); Busy is counted before Done.
  task automatic wait_done(bit sel8, output int lat, output int busy, output bit seen,
                           output logic [2:0] flags);
    lat   = 0;
    busy  = 0;
    seen  = 1'b0;
    flags = 3'bxxx;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (sel8 ? m8.Done : m64.Done) begin
        seen  = 1'b1;
        flags = sel8 ? {m8.A_EQ_B, m8.A_GT_B, m8.A_LT_B}
                     : {m64.A_EQ_B, m64.A_GT_B, m64.A_LT_B};
      end else begin
        if (sel8 ? m8.Busy : m64.Busy) busy++;
        @(negedge clk);
        lat++;
      end
    end
  endtask

  task automatic test_reset();
    m64.Start = 1'b0; m64.TwosComplement = 1'b0; m64.DataA = '0; m64.DataB = '0;
    m8.Start  = 1'b0; m8.TwosComplement  = 1'b0; m8.DataA  = '0; m8.DataB  = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({m64.Busy, m64.Done, m64.A_EQ_B, m64.A_GT_B, m64.A_LT_B} !== 5'b0) begin
      failures++;
      $display("FAIL reset64 got=%b exp=00000",
               {m64.Busy, m64.Done, m64.A_EQ_B, m64.A_GT_B, m64.A_LT_B});
    end
    checks++;
    if ({m8.Busy, m8.Done, m8.A_EQ_B, m8.A_GT_B, m8.A_LT_B} !== 5'b0) begin
      failures++;
      $display("FAIL reset8 got=%b exp=00000",
               {m8.Busy, m8.Done, m8.A_EQ_B, m8.A_GT_B, m8.A_LT_B});
    end
  endtask

  task automatic test_unsigned_low_slice();
    int lat, busy; bit seen; logic [2:0] flags; exp_t e;
    drive_start(1'b0, 64'h5, 64'h3, 1'b0);
    wait_done(1'b0, lat, busy, seen, flags);
    e = sb.pop_front();
    checks++;
    if ({seen, flags} !== {1'b1, e.flags}) begin
      failures++; $display("FAIL low_slice_flags got=%b exp=%b", {seen, flags}, {1'b1, e.flags});
    end
    checks++;
    if (lat !== e.lat || busy !== e.lat) begin
      failures++; $display("FAIL low_slice_lat got lat=%0d busy=%0d exp=%0d", lat, busy, e.lat);
    end
    @(negedge clk);
    checks++;
    if (m64.Done !== 1'b0) begin
      failures++; $display("FAIL done_pulse got=%b exp=0", m64.Done);
    end
  endtask

  task automatic test_sign_top_slice();
    int lat, busy; bit seen; logic [2:0] flags; exp_t e;
    for (int i = 0; i < 2; i++) begin
      drive_start(1'b0, 64'h8000_0000_0000_0000, 64'h1, (i == 0));
      wait_done(1'b0, lat, busy, seen, flags);
      e = sb.pop_front();
      checks++;
      if ({seen, flags} !== {1'b1, e.flags}) begin
        failures++;
        $display("FAIL sign_top_flags[%0d] got=%b exp=%b", i, {seen, flags}, {1'b1, e.flags});
      end
      checks++;
      if (lat !== e.lat || busy !== e.lat) begin
        failures++;
        $display("FAIL sign_top_lat[%0d] got lat=%0d busy=%0d exp=%0d", i, lat, busy, e.lat);
      end
    end
  endtask

  task automatic test_equal();
    int lat, busy; bit seen; logic [2:0] flags; exp_t e;
    drive_start(1'b0, 64'hDEAD_BEEF_CAFE_F00D, 64'hDEAD_BEEF_CAFE_F00D, 1'b1);
    wait_done(1'b0, lat, busy, seen, flags);
    e = sb.pop_front();
    checks++;
    if ({seen, flags} !== {1'b1, e.flags}) begin
      failures++; $display("FAIL equal_flags got=%b exp=%b", {seen, flags}, {1'b1, e.flags});
    end
    checks++;
    if (lat !== e.lat || busy !== e.lat) begin
      failures++; $display("FAIL equal_lat got lat=%0d busy=%0d exp=%0d", lat, busy, e.lat);
    end
  endtask

  task automatic test_back_to_back();
    int lat, busy; bit seen; logic [2:0] flags; exp_t e;
    drive_start(1'b0, 64'h1, 64'h2, 1'b0);
    // Start while busy must be ignored.
    m64.Start = 1'b1; m64.DataA = 64'h9; m64.DataB = 64'h0; m64.TwosComplement = 1'b0;
    fork
      begin
        @(negedge clk);
        m64.Start = 1'b0;
      end
    join_none
    wait_done(1'b0, lat, busy, seen, flags);
    e = sb.pop_front();
    checks++;
    if ({seen, flags} !== {1'b1, e.flags}) begin
      failures++; $display("FAIL ignore_flags got=%b exp=%b", {seen, flags}, {1'b1, e.flags});
    end
    checks++;
    if (lat !== e.lat || busy !== e.lat) begin
      failures++; $display("FAIL ignore_lat got lat=%0d busy=%0d exp=%0d", lat, busy, e.lat);
    end
    // Start in the Done cycle is accepted; old result stays visible meanwhile.
    drive_start(1'b0, 64'h9, 64'h0, 1'b0);
    checks++;
    if ({m64.Busy, m64.A_EQ_B, m64.A_GT_B, m64.A_LT_B} !== 4'b1001) begin
      failures++;
      $display("FAIL hold_result got=%b exp=1001",
               {m64.Busy, m64.A_EQ_B, m64.A_GT_B, m64.A_LT_B});
    end
    wait_done(1'b0, lat, busy, seen, flags);
    e = sb.pop_front();
    checks++;
    if ({seen, flags} !== {1'b1, e.flags}) begin
      failures++; $display("FAIL b2b_flags got=%b exp=%b", {seen, flags}, {1'b1, e.flags});
    end
    checks++;
    if (lat !== e.lat || busy !== e.lat) begin
      failures++; $display("FAIL b2b_lat got lat=%0d busy=%0d exp=%0d", lat, busy, e.lat);
    end
  endtask

  task automatic test_reset_midop();
    int lat, busy, ndone; bit seen; logic [2:0] flags; exp_t e;
    drive_start(1'b0, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    // Reset wins over a simultaneous Start.
    m64.Start = 1'b1; m64.DataA = 64'h7; m64.DataB = 64'h0;
    @(negedge clk);
    rst = 1'b0;
    m64.Start = 1'b0;
    void'(sb.pop_front());
    checks++;
    if ({m64.Busy, m64.Done, m64.A_EQ_B, m64.A_GT_B, m64.A_LT_B} !== 5'b0) begin
      failures++;
      $display("FAIL midop_reset got=%b exp=00000",
               {m64.Busy, m64.Done, m64.A_EQ_B, m64.A_GT_B, m64.A_LT_B});
    end
    ndone = 0;
    repeat (8) begin
      @(negedge clk);
      if (m64.Done) ndone++;
    end
    checks++;
    if (ndone !== 0) begin
      failures++; $display("FAIL midop_no_done got=%0d exp=0", ndone);
    end
    drive_start(1'b0, 64'h0001_0000_0000_0000, 64'h0002_0000_0000_0000, 1'b0);
    wait_done(1'b0, lat, busy, seen, flags);
    e = sb.pop_front();
    checks++;
    if ({seen, flags} !== {1'b1, e.flags} || lat !== e.lat || busy !== e.lat) begin
      failures++;
      $display("FAIL after_reset got=%b lat=%0d busy=%0d exp=%b lat=%0d",
               {seen, flags}, lat, busy, {1'b1, e.flags}, e.lat);
    end
  endtask

  task automatic test_narrow();
    int lat, busy; bit seen; logic [2:0] flags; exp_t e;
    for (int i = 0; i < 3; i++) begin
      drive_start(1'b1, 64'hFF, (i == 2) ? 64'hFF : 64'h01, (i != 1));
      wait_done(1'b1, lat, busy, seen, flags);
      e = sb.pop_front();
      checks++;
      if ({seen, flags} !== {1'b1, e.flags} || lat !== e.lat || busy !== e.lat) begin
        failures++;
        $display("FAIL narrow[%0d] got=%b lat=%0d busy=%0d exp=%b lat=%0d",
                 i, {seen, flags}, lat, busy, {1'b1, e.flags}, e.lat);
      end
    end
  endtask

  task automatic test_random();
    int lat, busy; bit seen; logic [2:0] flags; exp_t e;
    logic [63:0] a, b;
    bit tc;
    for (int i = 0; i < 12; i++) begin
      a  = {$urandom, $urandom};
      b  = a;
      for (int k = 0; k < 4; k++) begin
        if ($urandom_range(0, 2) == 0) b[k*16 +: 16] = 16'($urandom);
      end
      tc = 1'($urandom_range(0, 1));
      drive_start(1'b0, a, b, tc);
      wait_done(1'b0, lat, busy, seen, flags);
      e = sb.pop_front();
      checks++;
      if ({seen, flags} !== {1'b1, e.flags} || lat !== e.lat || busy !== e.lat) begin
        failures++;
        $display("FAIL random[%0d] a=%h b=%h tc=%b got=%b lat=%0d busy=%0d exp=%b lat=%0d",
                 i, a, b, tc, {seen, flags}, lat, busy, {1'b1, e.flags}, e.lat);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    @(negedge clk);
    test_reset();
    test_unsigned_low_slice();
    test_sign_top_slice();
    test_equal();
    test_back_to_back();
    test_reset_midop();
    test_narrow();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
